// File: rtl/reg_file_master.sv
// reg_file_master: sequencing initiator for a three-port register file.
// Zeroes every register after reset, then serves one operand-fetch/writeback request at a time.
module reg_file_master #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 32,
    parameter int INIT_CLEAR = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Req_Valid,
    output logic              Req_Ready,
    input  logic [ADDR_W-1:0] Req_Rs1,
    input  logic [ADDR_W-1:0] Req_Rs2,
    input  logic [ADDR_W-1:0] Req_Rd,
    input  logic              Req_Wr_En,
    input  logic [DATA_W-1:0] Req_Wr_Data,
    output logic              Rsp_Valid,
    input  logic              Rsp_Ready,
    output logic [DATA_W-1:0] Rsp_Data1,
    output logic [DATA_W-1:0] Rsp_Data2,
    output logic              Busy,
    output logic [ADDR_W-1:0] Read_Register1,
    output logic [ADDR_W-1:0] Read_Register2,
    input  logic [DATA_W-1:0] Read_Data1,
    input  logic [DATA_W-1:0] Read_Data2,
    output logic [ADDR_W-1:0] Write_Register,
    output logic [DATA_W-1:0] Write_Data,
    output logic              Reg_Write
);

    // The sweep counter needs one extra bit so it can hold NUM_REGS as its terminal value.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  SWEEP_END = CNT_W'(NUM_REGS);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam state_t RESET_STATE = (INIT_CLEAR != 0) ? INIT : IDLE;

    state_t              state_r;
    state_t              state_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_s;
    logic                accept_s;
    logic                req_ready_r;
    logic [ADDR_W-1:0]   rd_r;
    logic                wr_en_r;
    logic [DATA_W-1:0]   wr_data_r;
    logic [ADDR_W-1:0]   read_reg1_r;
    logic [ADDR_W-1:0]   read_reg2_r;
    logic [DATA_W-1:0]   rsp_data1_r;
    logic [DATA_W-1:0]   rsp_data2_r;
    logic                reg_write_r;
    logic                reg_write_s;
    logic [ADDR_W-1:0]   write_reg_r;
    logic [ADDR_W-1:0]   write_reg_s;
    logic [DATA_W-1:0]   write_data_r;
    logic [DATA_W-1:0]   write_data_s;

    assign accept_s = Req_Valid & req_ready_r;

    // State and sweep-counter register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= RESET_STATE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic and the write-port values for the coming cycle.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        reg_write_s  = 1'b0;
        write_reg_s  = write_reg_r;
        write_data_s = write_data_r;
        case (state_r)
            INIT: begin
                // Cycle right after reset is spent priming; writes start on the first edge.
                if (cnt_r == SWEEP_END) begin
                    state_s = IDLE;
                end else begin
                    reg_write_s  = 1'b1;
                    write_reg_s  = cnt_r[ADDR_W-1:0];
                    write_data_s = DATA_ZERO;
                    cnt_s        = cnt_r + CNT_ONE;
                end
            end
            IDLE: begin
                if (accept_s) begin
                    state_s = READ;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                if (wr_en_r && (rd_r != ADDR_ZERO)) begin
                    state_s      = WRITE;
                    reg_write_s  = 1'b1;
                    write_reg_s  = rd_r;
                    write_data_s = wr_data_r;
                end else begin
                    state_s = RESP;
                end
            end
            WRITE: begin
                state_s = RESP;
            end
            RESP: begin
                if (Rsp_Ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = RESET_STATE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Registered outputs, request latch and operand capture.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req_ready_r  <= 1'b0;
            rd_r         <= ADDR_ZERO;
            wr_en_r      <= 1'b0;
            wr_data_r    <= DATA_ZERO;
            read_reg1_r  <= ADDR_ZERO;
            read_reg2_r  <= ADDR_ZERO;
            rsp_data1_r  <= DATA_ZERO;
            rsp_data2_r  <= DATA_ZERO;
            reg_write_r  <= 1'b0;
            write_reg_r  <= ADDR_ZERO;
            write_data_r <= DATA_ZERO;
        end else begin
            req_ready_r  <= (state_s == IDLE);
            reg_write_r  <= reg_write_s;
            write_reg_r  <= write_reg_s;
            write_data_r <= write_data_s;
            if (accept_s) begin
                read_reg1_r <= Req_Rs1;
                read_reg2_r <= Req_Rs2;
                rd_r        <= Req_Rd;
                wr_en_r     <= Req_Wr_En;
                wr_data_r   <= Req_Wr_Data;
            end
            // Operands are sampled before this request's own write lands.
            if (state_r == READ) begin
                rsp_data1_r <= Read_Data1;
                rsp_data2_r <= Read_Data2;
            end
        end
    end

    assign Req_Ready      = req_ready_r;
    assign Rsp_Valid      = (state_r == RESP);
    assign Busy           = (state_r != IDLE);
    assign Rsp_Data1      = rsp_data1_r;
    assign Rsp_Data2      = rsp_data2_r;
    assign Read_Register1 = read_reg1_r;
    assign Read_Register2 = read_reg2_r;
    assign Write_Register = write_reg_r;
    assign Write_Data     = write_data_r;
    assign Reg_Write      = reg_write_r;

endmodule

// File: tb/tb_reg_file_master.sv
// tb_reg_file_master: random and directed transactions against a register-file reference model.
// The bench also provides the combinational-read register file the initiator drives.
module tb_reg_file_master;

    localparam int NREG = 32;

    logic        CLK;
    logic        RST;
    logic        Req_Valid;
    logic        Req_Ready;
    logic [4:0]  Req_Rs1;
    logic [4:0]  Req_Rs2;
    logic [4:0]  Req_Rd;
    logic        Req_Wr_En;
    logic [31:0] Req_Wr_Data;
    logic        Rsp_Valid;
    logic        Rsp_Ready;
    logic [31:0] Rsp_Data1;
    logic [31:0] Rsp_Data2;
    logic        Busy;
    logic [4:0]  Read_Register1;
    logic [4:0]  Read_Register2;
    logic [31:0] Read_Data1;
    logic [31:0] Read_Data2;
    logic [4:0]  Write_Register;
    logic [31:0] Write_Data;
    logic        Reg_Write;

    logic [31:0] rf     [0:NREG-1];
    logic [31:0] ref_rf [0:NREG-1];
    logic        rf_scramble;
    logic [31:0] last1;
    logic [31:0] last2;
    int          vec_cnt;
    int          err_cnt;

    reg_file_master dut (
        .CLK(CLK), .RST(RST),
        .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
        .Req_Rs1(Req_Rs1), .Req_Rs2(Req_Rs2), .Req_Rd(Req_Rd),
        .Req_Wr_En(Req_Wr_En), .Req_Wr_Data(Req_Wr_Data),
        .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready),
        .Rsp_Data1(Rsp_Data1), .Rsp_Data2(Rsp_Data2),
        .Busy(Busy),
        .Read_Register1(Read_Register1), .Read_Register2(Read_Register2),
        .Read_Data1(Read_Data1), .Read_Data2(Read_Data2),
        .Write_Register(Write_Register), .Write_Data(Write_Data),
        .Reg_Write(Reg_Write)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register file the initiator drives; scrambled during reset so the sweep is observable.
    always @(posedge CLK) begin
        if (rf_scramble) begin
            for (int i = 0; i < NREG; i++) rf[i] <= $urandom | 32'h1;
        end else if (Reg_Write) begin
            rf[Write_Register] <= Write_Data;
        end
    end

    assign Read_Data1 = rf[Read_Register1];
    assign Read_Data2 = rf[Read_Register2];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Releases reset (called #1 after an edge) and follows the zeroing sweep.
    task automatic run_sweep();
        int bad;
        bad = 0;
        RST = 1'b0;
        check_eq("sweep_c0_reg_write", Reg_Write, 1'b0);
        for (int k = 1; k <= NREG; k++) begin
            @(posedge CLK); #1;
            if (Reg_Write !== 1'b1 || Write_Register !== 5'(k - 1) || Write_Data !== 32'h0 ||
                Req_Ready !== 1'b0 || Busy !== 1'b1 || Rsp_Valid !== 1'b0) bad++;
        end
        check_eq("sweep_cycles_bad", bad, 0);
        @(posedge CLK); #1;
        check_eq("post_sweep_ready", Req_Ready, 1'b1);
        check_eq("post_sweep_reg_write", Reg_Write, 1'b0);
        check_eq("post_sweep_busy", Busy, 1'b0);
        check_eq("post_sweep_rsp_valid", Rsp_Valid, 1'b0);
        bad = 0;
        for (int i = 0; i < NREG; i++) begin
            if (rf[i] !== 32'h0) bad++;
            ref_rf[i] = 32'h0;
        end
        check_eq("post_sweep_rf_nonzero", bad, 0);
    endtask

    // One full transaction; expectations come from ref_rf and the protocol timing rules.
    task automatic do_txn(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic we, input logic [31:0] wd, input int stall);
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic [4:0]  p_addr;
        logic [31:0] p_data;
        logic        exp_wr;
        int          n;
        int          lat;
        int          pulses;
        int          bad;
        exp1   = ref_rf[rs1];
        exp2   = ref_rf[rs2];
        exp_wr = we && (rd != 5'd0);
        p_addr = 5'd0;
        p_data = 32'h0;
        n = 0;
        while (Req_Ready !== 1'b1 && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        if (Req_Ready !== 1'b1) begin
            check_eq("req_ready_timeout", Req_Ready, 1'b1);
            return;
        end
        Req_Valid = 1'b1; Req_Rs1 = rs1; Req_Rs2 = rs2; Req_Rd = rd;
        Req_Wr_En = we; Req_Wr_Data = wd;
        @(posedge CLK); #1;
        Req_Valid = 1'b0; Req_Rs1 = 5'($urandom); Req_Rs2 = 5'($urandom);
        Req_Rd = 5'($urandom); Req_Wr_En = 1'($urandom); Req_Wr_Data = $urandom;
        check_eq("ready_drop", Req_Ready, 1'b0);
        lat = 1;
        pulses = 0;
        while (Rsp_Valid !== 1'b1 && lat < 20) begin
            if (Reg_Write === 1'b1) begin
                pulses++;
                p_addr = Write_Register;
                p_data = Write_Data;
            end
            @(posedge CLK); #1;
            lat++;
        end
        check_eq("rsp_latency", lat, exp_wr ? 3 : 2);
        check_eq("wr_pulses", pulses, exp_wr ? 1 : 0);
        if (exp_wr) begin
            check_eq("wr_addr", p_addr, rd);
            check_eq("wr_data", p_data, wd);
        end
        bad = 0;
        for (int i = 0; i < stall; i++) begin
            @(posedge CLK); #1;
            if (Rsp_Valid !== 1'b1 || Rsp_Data1 !== exp1 || Rsp_Data2 !== exp2 ||
                Req_Ready !== 1'b0 || Busy !== 1'b1 || Reg_Write !== 1'b0) bad++;
        end
        if (stall > 0) check_eq("stall_hold_bad", bad, 0);
        check_eq("rsp_data1", Rsp_Data1, exp1);
        check_eq("rsp_data2", Rsp_Data2, exp2);
        last1 = Rsp_Data1;
        last2 = Rsp_Data2;
        Rsp_Ready = 1'b1;
        @(posedge CLK); #1;
        Rsp_Ready = 1'b0;
        check_eq("rsp_valid_drop", Rsp_Valid, 1'b0);
        check_eq("idle_ready", Req_Ready, 1'b1);
        check_eq("idle_busy", Busy, 1'b0);
        if (exp_wr) ref_rf[rd] = wd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        logic [4:0] r1;
        logic [4:0] r2;
        logic [4:0] rdv;
        int bad;
        vec_cnt = 0; err_cnt = 0;
        last1 = 32'h0; last2 = 32'h0;
        RST = 1'b1; rf_scramble = 1'b1;
        Req_Valid = 1'b0; Req_Rs1 = 5'd0; Req_Rs2 = 5'd0; Req_Rd = 5'd0;
        Req_Wr_En = 1'b0; Req_Wr_Data = 32'h0; Rsp_Ready = 1'b0;
        for (int i = 0; i < NREG; i++) ref_rf[i] = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        check_eq("rst_req_ready", Req_Ready, 1'b0);
        check_eq("rst_rsp_valid", Rsp_Valid, 1'b0);
        check_eq("rst_busy", Busy, 1'b1);
        check_eq("rst_reg_write", Reg_Write, 1'b0);
        check_eq("rst_write_reg", Write_Register, 5'd0);
        check_eq("rst_write_data", Write_Data, 32'h0);
        check_eq("rst_read_reg1", Read_Register1, 5'd0);
        check_eq("rst_rsp_data1", Rsp_Data1, 32'h0);
        rf_scramble = 1'b0;
        run_sweep();

        do_txn(5'd0, 5'd0, 5'd5, 1'b1, 32'hDEADBEEF, 0);
        do_txn(5'd5, 5'd0, 5'd0, 1'b0, 32'h0, 0);
        check_eq("t2_data1", last1, 32'hDEADBEEF);
        check_eq("t2_data2", last2, 32'h0);

        do_txn(5'd0, 5'd0, 5'd7, 1'b1, 32'h0000AAAA, 0);
        do_txn(5'd7, 5'd5, 5'd7, 1'b1, 32'h00001234, 1);
        check_eq("t3_read_old", last1, 32'h0000AAAA);
        do_txn(5'd7, 5'd7, 5'd0, 1'b0, 32'h0, 0);
        check_eq("t3_read_new", last1, 32'h00001234);

        do_txn(5'd0, 5'd0, 5'd0, 1'b1, 32'hFFFFFFFF, 0);
        do_txn(5'd0, 5'd7, 5'd3, 1'b0, 32'h0, 0);
        check_eq("t4_r0_zero", last1, 32'h0);

        do_txn(5'd5, 5'd7, 5'd12, 1'b1, 32'h0BADF00D, 10);

        for (int t = 0; t < 40; t++) begin
            r1  = 5'($urandom);
            r2  = 5'($urandom);
            rdv = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK); #1;
            end
            do_txn(r1, r2, rdv, 1'($urandom), $urandom, int'($urandom_range(0, 3)));
        end

        bad = 0;
        for (int i = 0; i < NREG; i++) if (rf[i] !== ref_rf[i]) bad++;
        check_eq("rf_vs_model_bad", bad, 0);

        // Reset during the WRITE cycle of a request to r9.
        do_txn(5'd0, 5'd0, 5'd9, 1'b1, 32'h00000077, 0);
        Req_Valid = 1'b1; Req_Rs1 = 5'd9; Req_Rs2 = 5'd9; Req_Rd = 5'd9;
        Req_Wr_En = 1'b1; Req_Wr_Data = 32'h00000055;
        @(posedge CLK); #1;
        Req_Valid = 1'b0;
        @(posedge CLK); #1;
        check_eq("rst_mid_pre_write", Reg_Write, 1'b1);
        #2;
        RST = 1'b1;
        #1;
        check_eq("rst_mid_async_drop", Reg_Write, 1'b0);
        check_eq("rst_mid_rsp_valid", Rsp_Valid, 1'b0);
        @(posedge CLK); #1;
        check_eq("rst_mid_r9_kept", rf[9], 32'h00000077);
        @(posedge CLK); #1;
        run_sweep();
        do_txn(5'd9, 5'd5, 5'd0, 1'b0, 32'h0, 0);
        check_eq("rst_mid_r9_zero", last1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/reg_file_master.md
Name: reg_file_master

Overview:
- Sequencing initiator that drives the 32x32 three-port register file.
- Accepts one operand-fetch/writeback request per transaction over a valid/ready handshake.
- Drives the register file's read and write address, data and enable pins, captures the two read operands, and returns them over a valid/ready response channel.
- After reset it sweeps every register to zero before accepting traffic. It sits between the datapath control and the register file.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- NUM_REGS, 32, registers cleared by the init sweep (2**ADDR_W).
- INIT_CLEAR, 1, 1 runs the zeroing sweep after reset; 0 goes straight to IDLE.

Ports:
- CLK input 1 — single clock, rising edge.
- RST input 1 — asynchronous, active-high reset.
- Req_Valid input 1 — request valid.
- Req_Ready output 1 — request accepted when Req_Valid and Req_Ready are both high at a rising edge.
- Req_Rs1 input ADDR_W — read address 1.
- Req_Rs2 input ADDR_W — read address 2.
- Req_Rd input ADDR_W — write address.
- Req_Wr_En input 1 — request includes a write.
- Req_Wr_Data input DATA_W — write data.
- Rsp_Valid output 1 — operands valid.
- Rsp_Ready input 1 — consumer accepts the response.
- Rsp_Data1 output DATA_W — operand from Rs1.
- Rsp_Data2 output DATA_W — operand from Rs2.
- Busy output 1 — high in every state except IDLE.
- Read_Register1 output ADDR_W — to register file.
- Read_Register2 output ADDR_W — to register file.
- Read_Data1 input DATA_W — from register file (combinational read).
- Read_Data2 input DATA_W — from register file.
- Write_Register output ADDR_W — to register file.
- Write_Data output DATA_W — to register file.
- Reg_Write output 1 — register file write enable.

Behaviour:
- Clock and reset: one clock CLK. RST is asynchronous, active-high. All registered state clears immediately on RST assertion.
- Reset values:
  - State=INIT when INIT_CLEAR=1, otherwise IDLE.
  - Req_Ready=0, Rsp_Valid=0, Rsp_Data1/2=0, Busy=1 (0 if INIT_CLEAR=0).
  - All address outputs=0, Write_Data=0, Reg_Write=0.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.
- INIT:
  - The counter runs 0..NUM_REGS-1, one register per cycle.
  - Write_Register=counter, Write_Data=0, Reg_Write=1.
  - After the counter reaches NUM_REGS-1, the next state is IDLE.
  - Sweep lasts exactly NUM_REGS cycles after RST deassertion. Req_Ready=0 throughout.
- IDLE:
  - Req_Ready=1, Busy=0.
  - On handshake: latch Rs1, Rs2, Rd, Wr_En, Wr_Data; next state READ.
  - With no handshake, stay in IDLE. Req_Ready drops the cycle after acceptance, so there are no back-to-back accepts.
- READ (1 cycle):
  - Read_Register1/2 hold the latched Rs1/Rs2; Reg_Write=0.
  - At the end of the cycle, capture Read_Data1/2 into Rsp_Data1/2.
  - Next state is WRITE if latched Wr_En=1 and Rd!=0; otherwise RESP.
- WRITE (1 cycle):
  - Write_Register=Rd, Write_Data=Wr_Data, Reg_Write=1 for exactly one cycle. Next state RESP.
  - Writes to register 0 are suppressed: Reg_Write is never asserted for Rd=0 outside INIT.
- RESP:
  - Rsp_Valid=1. Rsp_Data1/2 hold stable until the handshake.
  - On Rsp_Valid && Rsp_Ready: Rsp_Valid=0 next cycle; next state IDLE.
  - Without Rsp_Ready, hold indefinitely.
- Read-old semantics: operands always reflect register contents before this request's own write. An Rs1/Rs2 equal to Rd returns the old value.
- Address and data outputs are stable whenever Reg_Write=1. Outside WRITE and INIT, Write_Register/Write_Data hold their last value.
- Minimum transaction is 3 cycles (IDLE accept, READ, RESP), or 4 with a write, when Rsp_Ready is high.
- Reset mid-transaction: the in-flight request is dropped and its write is not issued. Reg_Write deasserts asynchronously, then the INIT sweep restarts.

Test Plan:
- Reset release with INIT_CLEAR=1 -> Reg_Write high for exactly 32 consecutive cycles, Write_Register 0..31, Write_Data=0. Req_Ready first high on the cycle after the sweep (cycle 33).
- Request Rd=5, Wr_En=1, Wr_Data=0xDEADBEEF, then request Rs1=5, Rs2=0 -> exactly one Reg_Write pulse to address 5. Second response Rsp_Data1=0xDEADBEEF, Rsp_Data2=0.
- Request Rs1=7, Rd=7, Wr_En=1, Wr_Data=0x1234 after r7=0xAAAA -> Rsp_Data1=0xAAAA. A following read of r7 returns 0x1234.
- Request Rd=0, Wr_En=1, Wr_Data=0xFFFFFFFF -> no Reg_Write pulse. Rsp_Valid after 2 cycles; a later read of r0 returns 0.
- Rsp_Ready held low for 10 cycles -> Rsp_Valid and Rsp_Data1/2 stable, Req_Ready=0, Busy=1. Rsp_Ready high -> IDLE on the next cycle.
- RST asserted during the WRITE cycle -> Reg_Write falls without waiting for a clock edge. The target register is rewritten only by the sweep (value 0), and Rsp_Valid never asserts for the dropped request.
